// File: rtl/phase_scheduler_if.sv
// Handshake/status bundle between the phase scheduler and its controller.
// master: the controlling side (drives start/stop/ped_req).
// slave : the scheduler itself.
interface phase_scheduler_if #(
  parameter int SEC_W = 8
);
  logic             start;
  logic             stop;
  logic             ped_req;
  logic             ped_ack;
  logic [2:0]       state_reg;
  logic [2:0]       state_next;
  logic [SEC_W-1:0] sec_cnt;
  logic             tick;
  logic [2:0]       lights;

  modport master (
    output start, stop, ped_req,
    input  ped_ack, state_reg, state_next, sec_cnt, tick, lights
  );

  modport slave (
    input  start, stop, ped_req,
    output ped_ack, state_reg, state_next, sec_cnt, tick, lights
  );
endinterface

// File: rtl/phase_scheduler.sv
// phase_scheduler: light-phase sequencer (IDLE/RED/RED_YELLOW/GREEN/YELLOW).
// Divides clk into a 1 s tick and holds each phase for its length in seconds.
// Optional pedestrian early-GREEN-cut feature: define PHASE_SCHED_PED_REQ_EN.
module phase_scheduler #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int T_RED         = 10,
  parameter int T_RY          = 2,
  parameter int T_GREEN       = 10,
  parameter int T_YELLOW      = 3,
  parameter int T_PED_MIN     = 4,
  parameter int SEC_W         = 8
) (
  input logic              clk,
  input logic              rst,
  phase_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RED        = 3'd1,
    RED_YELLOW = 3'd2,
    GREEN      = 3'd3,
    YELLOW     = 3'd4
  } phase_t;

  localparam int               PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [SEC_W-1:0] SEC_MAX    = '1;

  phase_t           state_reg;
  phase_t           state_next;
  logic [PW-1:0]    presc_reg;
  logic [SEC_W-1:0] sec_cnt_reg;
  logic [2:0]       lights_reg;
  logic [2:0]       lights_next;
  logic [SEC_W-1:0] phase_last;
  logic             tick;
  logic             phase_end;
  logic             ped_cut;
  logic             ped_min_reached;
  logic             phase_change;

  // Last whole-second index of the current phase (T_x - 1)
  always_comb begin
    phase_last = '0;
    case (state_reg)
      RED:        phase_last = SEC_W'(T_RED - 1);
      RED_YELLOW: phase_last = SEC_W'(T_RY - 1);
      GREEN:      phase_last = SEC_W'(T_GREEN - 1);
      YELLOW:     phase_last = SEC_W'(T_YELLOW - 1);
      default:    phase_last = '0;
    endcase
  end

  // The prescaler never leaves 0 in IDLE, so tick is naturally quiet there
  assign tick            = (state_reg != IDLE) && (presc_reg == PRESC_LAST);
  assign ped_min_reached = (sec_cnt_reg >= SEC_W'(T_PED_MIN - 1));
  assign phase_end       = tick && ((sec_cnt_reg == phase_last) || ped_cut);
  assign phase_change    = (state_next != state_reg);

`ifdef PHASE_SCHED_PED_REQ_EN
  logic pending_reg;
  logic ped_ack_reg;
  logic ped_accept;

  assign ped_accept = bus.ped_req && (state_reg != IDLE) && !pending_reg;
  assign ped_cut    = (state_reg == GREEN) && pending_reg && ped_min_reached;

  // Latch one pedestrian request per cycle of phases; cleared on stop and RED entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg <= 1'b0;
      ped_ack_reg <= 1'b0;
    end else if (bus.stop || (state_next == RED && state_reg != RED)) begin
      pending_reg <= 1'b0;
      ped_ack_reg <= 1'b0;
    end else begin
      ped_ack_reg <= ped_accept;
      if (ped_accept) begin
        pending_reg <= 1'b1;
      end
    end
  end

  assign bus.ped_ack = ped_ack_reg;
`else
  logic unused_ped;

  assign ped_cut     = 1'b0;
  assign unused_ped  = bus.ped_req ^ ped_min_reached;
  assign bus.ped_ack = 1'b0;
`endif

  // Next-phase decode: stop first, then start from IDLE, then phase end
  always_comb begin
    state_next = state_reg;
    if (bus.stop) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:       if (bus.start) state_next = RED;
        RED:        if (phase_end) state_next = RED_YELLOW;
        RED_YELLOW: if (phase_end) state_next = GREEN;
        GREEN:      if (phase_end) state_next = YELLOW;
        YELLOW:     if (phase_end) state_next = RED;
        default:    state_next = IDLE;
      endcase
    end
  end

  // Lamp decode from the upcoming phase so lamps switch with state_reg
  always_comb begin
    lights_next = 3'b000;
    case (state_next)
      RED:        lights_next = 3'b100;
      RED_YELLOW: lights_next = 3'b110;
      GREEN:      lights_next = 3'b001;
      YELLOW:     lights_next = 3'b010;
      default:    lights_next = 3'b000;
    endcase
  end

  // Phase register and registered lamps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      lights_reg <= 3'b000;
    end else begin
      state_reg  <= state_next;
      lights_reg <= lights_next;
    end
  end

  // Prescaler and seconds counter; any phase change restarts both at 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg   <= '0;
      sec_cnt_reg <= '0;
    end else if (phase_change) begin
      presc_reg   <= '0;
      sec_cnt_reg <= '0;
    end else if (state_reg != IDLE) begin
      presc_reg <= tick ? '0 : presc_reg + 1'b1;
      if (tick && sec_cnt_reg != SEC_MAX) begin
        sec_cnt_reg <= sec_cnt_reg + 1'b1;
      end
    end
  end

  assign bus.state_reg  = state_reg;
  assign bus.state_next = state_next;
  assign bus.sec_cnt    = sec_cnt_reg;
  assign bus.tick       = tick;
  assign bus.lights     = lights_reg;

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed bench for phase_scheduler with TICKS_PER_SEC=4, T_RED=3, T_RY=1,
// T_GREEN=4, T_YELLOW=2, T_PED_MIN=1. Outputs are sampled on the falling edge.
module tb_phase_scheduler;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  phase_scheduler_if #(.SEC_W(8)) bus ();

  phase_scheduler #(
    .TICKS_PER_SEC(4),
    .T_RED        (3),
    .T_RY         (1),
    .T_GREEN      (4),
    .T_YELLOW     (2),
    .T_PED_MIN    (1),
    .SEC_W        (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

`ifdef PHASE_SCHED_PED_REQ_EN
  localparam int PED_EN = 1;
`else
  localparam int PED_EN = 0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Walk cycles first..first+n-1 of a phase (4 clk per second); on the final
  // cycle of a full walk, also check the upcoming phase.
  task automatic run_phase(input string name, input int st, input int li,
                           input int first, input int n, input int nxt);
    $display("phase %s cycles %0d..%0d", name, first, first + n - 1);
    for (int k = first; k < first + n; k++) begin
      chk({name, "_state"}, 32'(bus.state_reg), 32'(st));
      chk({name, "_lights"}, 32'(bus.lights), 32'(li));
      chk({name, "_sec"}, 32'(bus.sec_cnt), 32'(k / 4));
      chk({name, "_tick"}, 32'(bus.tick), 32'((k % 4) == 3));
      if (k == first + n - 1 && nxt >= 0) begin
        chk({name, "_next"}, 32'(bus.state_next), 32'(nxt));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.ped_req = 1'b0;
    repeat (2) @(negedge clk);
    $display("step reset values");
    chk("rst_state", 32'(bus.state_reg), 32'd0);
    chk("rst_sec", 32'(bus.sec_cnt), 32'd0);
    chk("rst_lights", 32'(bus.lights), 32'd0);
    chk("rst_tick", 32'(bus.tick), 32'd0);
    chk("rst_ack", 32'(bus.ped_ack), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_state", 32'(bus.state_reg), 32'd0);

    // start and stop together in IDLE: stop wins, no tick
    $display("step start+stop in IDLE");
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("ss_next", 32'(bus.state_next), 32'd0);
      @(negedge clk);
      chk("ss_state", 32'(bus.state_reg), 32'd0);
      chk("ss_tick", 32'(bus.tick), 32'd0);
      chk("ss_lights", 32'(bus.lights), 32'd0);
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;

    // full cycle with wrap
    $display("step start pulse, full cycle");
    bus.start = 1'b1;
    #1;
    chk("start_next", 32'(bus.state_next), 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    run_phase("RED", 1, 4, 0, 12, 2);
    run_phase("RY", 2, 6, 0, 4, 3);
    run_phase("GREEN", 3, 1, 0, 16, 4);
    run_phase("YELLOW", 4, 2, 0, 8, 1);
    chk("wrap_state", 32'(bus.state_reg), 32'd1);
    chk("wrap_lights", 32'(bus.lights), 32'd4);
    chk("wrap_sec", 32'(bus.sec_cnt), 32'd0);

    // stop at cycle 5 of GREEN
    run_phase("RED", 1, 4, 0, 12, 2);
    run_phase("RY", 2, 6, 0, 4, 3);
    run_phase("GREEN", 3, 1, 0, 4, -1);
    $display("step stop at GREEN cycle 5");
    bus.stop = 1'b1;
    #1;
    chk("stop_next", 32'(bus.state_next), 32'd0);
    @(negedge clk);
    bus.stop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stop_state", 32'(bus.state_reg), 32'd0);
      chk("stop_lights", 32'(bus.lights), 32'd0);
      chk("stop_tick", 32'(bus.tick), 32'd0);
      chk("stop_sec", 32'(bus.sec_cnt), 32'd0);
      @(negedge clk);
    end
    $display("step restart after stop");
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    run_phase("RED", 1, 4, 0, 7, -1);

    // async reset mid-run at RED cycle 8 (tick high, sec_cnt 1)
    $display("step async reset mid-run");
    chk("pre_rst_tick", 32'(bus.tick), 32'd1);
    chk("pre_rst_sec", 32'(bus.sec_cnt), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", 32'(bus.state_reg), 32'd0);
    chk("arst_sec", 32'(bus.sec_cnt), 32'd0);
    chk("arst_lights", 32'(bus.lights), 32'd0);
    chk("arst_tick", 32'(bus.tick), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_idle", 32'(bus.state_reg), 32'd0);

    // pedestrian request in GREEN
    $display("step pedestrian request (ped_en=%0d)", PED_EN);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    run_phase("RED", 1, 4, 0, 12, 2);
    run_phase("RY", 2, 6, 0, 4, 3);
    bus.ped_req = 1'b1;
    chk("ped_g1_state", 32'(bus.state_reg), 32'd3);
    @(negedge clk);
    bus.ped_req = 1'b0;
    chk("ped_ack1", 32'(bus.ped_ack), 32'(PED_EN));
    @(negedge clk);
    chk("ped_ack_pulse", 32'(bus.ped_ack), 32'd0);
    bus.ped_req = 1'b1;
    @(negedge clk);
    bus.ped_req = 1'b0;
    chk("ped_ack_repeat", 32'(bus.ped_ack), 32'd0);
    chk("ped_g4_tick", 32'(bus.tick), 32'd1);
    if (PED_EN == 1) begin
      chk("ped_cut_next", 32'(bus.state_next), 32'd4);
      @(negedge clk);
      run_phase("YELLOW", 4, 2, 0, 8, 1);
    end else begin
      chk("noped_next", 32'(bus.state_next), 32'd3);
      run_phase("GREEN", 3, 1, 3, 13, 4);
      run_phase("YELLOW", 4, 2, 0, 8, 1);
    end
    $display("step pedestrian request after RED entry");
    chk("ped_red_state", 32'(bus.state_reg), 32'd1);
    bus.ped_req = 1'b1;
    @(negedge clk);
    bus.ped_req = 1'b0;
    chk("ped_ack_red", 32'(bus.ped_ack), 32'(PED_EN));
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    chk("final_idle", 32'(bus.state_reg), 32'd0);
    chk("final_ack", 32'(bus.ped_ack), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
